feature_matcher_par: RTL and testbench
======================================

Name: feature_matcher_par

Overview:
- Parallel, parametrised successor to the single-lane BRIEF matcher. Streams corners (coords + binary descriptor) over AXI-Stream and stores them in a ping-pong corner store.
- For each incoming corner, scans the previous frame LANES descriptors per cycle, applies runtime-configurable distance and ratio tests, and emits exactly one result record per input corner.
- Sits between the descriptor extractor and the pose/outlier stage.

Parameters:
NUM_BITS, 256, descriptor width in bits
COORD_W, 11, width of x and y coordinates
NUM_CORNERS, 1024, max stored corners per frame (power of 2)
LANES, 4, descriptors compared per cycle (power of 2, divides NUM_CORNERS)
DIST_W, 9, distance width, must satisfy 2^DIST_W > NUM_BITS
IN_W, 280, input tdata width (>= 2*COORD_W+NUM_BITS)
OUT_W, 64, output tdata width (>= 4*COORD_W+DIST_W+1)

Ports:
s00_axis_aclk  in  1  clock
s00_axis_aresetn  in  1  async active-low reset
s00_axis_tdata  in  IN_W  corner: {pad, y, x, desc}, desc in LSBs
s00_axis_tvalid  in  1  input valid
s00_axis_tlast  in  1  last corner of frame
s00_axis_tready  out  1  input ready
m00_axis_tdata  out  OUT_W  {pad, y_prev, x_prev, y_curr, x_curr, dist, match_ok}, match_ok at bit 0
m00_axis_tvalid  out  1  output valid
m00_axis_tlast  out  1  record of frame's last corner
m00_axis_tready  in  1  output ready
cfg_max_dist  in  DIST_W  accept only if D1 < cfg_max_dist
cfg_ratio_num  in  4  ratio test numerator
cfg_ratio_den  in  4  ratio test denominator

Behaviour:
- Reset (async assert, sync deassert): s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, state=IDLE, bank_sel=0, wr_ptr=0, prev_count=0. Reset mid-scan or mid-output abandons the corner. No partial record is emitted.
- States: IDLE -> SCAN -> DRAIN -> DECIDE -> OUTPUT -> IDLE.
- IDLE: s00_axis_tready=1. On handshake:
  - latch corner and tlast;
  - write to bank[bank_sel] at wr_ptr if wr_ptr < NUM_CORNERS, else drop storage only (corner is still matched);
  - wr_ptr saturates at NUM_CORNERS;
  - tready=0 next cycle.
  - Go to SCAN if prev_count>0, else DECIDE.
- SCAN: issue one read of LANES consecutive entries per cycle from bank[~bank_sel], base index 0, LANES, 2*LANES, ...; ceil(prev_count/LANES) cycles. Lanes whose index >= prev_count are masked (treated as distance = 2^DIST_W-1).
- Pipeline: BRAM read 1 cycle, XOR+popcount registered 1 cycle, min/second-min merge 1 cycle. DRAIN waits 3 cycles for the pipeline to empty.
- Merge: maintain D1<=D2 and best index/coords. Strict < comparison; on equal distance the lower index wins. Within a cycle, lanes are merged in ascending index. D1 and D2 initialise to NUM_BITS.
- DECIDE (1 cycle): match_ok = (prev_count>0) && (D1 < cfg_max_dist) && (D1*cfg_ratio_den < D2*cfg_ratio_num). Products are computed at DIST_W+4 bits, no overflow.
  - With a single candidate, D2 stays NUM_BITS (sentinel).
  - cfg_ratio_den=0 disables the ratio test.
  - If !match_ok: prev coords=0 and dist=D1 (NUM_BITS when prev_count=0).
- OUTPUT: m00_axis_tvalid=1 with stable tdata/tlast until m00_axis_tready. tlast = latched input tlast.
  - On handshake: tvalid=0.
  - If tlast: bank_sel toggles, prev_count=min(wr_ptr_after_write, NUM_CORNERS), wr_ptr=0.
  - Next state is IDLE.
- Per-corner latency, input handshake to tvalid: ceil(prev_count/LANES)+5 cycles (2 when prev_count=0).
- cfg_* are sampled in DECIDE only; changes take effect on the next record.

Optional Feature:
STATS_EN:
- Defined: adds outputs stat_matches (16), stat_dropped (16), stat_frame_done (1). The counters count match_ok records and storage-dropped corners in the current frame, saturate at 0xFFFF, and transfer to the outputs at frame swap. stat_frame_done pulses 1 cycle at that swap. All three reset to 0.
- Undefined: these ports and all counter logic are absent.

Test Plan:
- Frame A with 3 corners, tlast on the 3rd -> 3 records, match_ok=0, dist=256, tlast only on 3rd; prev_count=3.
- Frame B corner with desc identical to A[1] and >=40 bits from the others; cfg_max_dist=40, num=4, den=5 -> match_ok=1, dist=0, prev coords = A[1].
- Frame B corner at distance 10 from A[0] and 11 from A[2] -> ratio test fails (50 !< 44), match_ok=0, dist=10.
- prev_count=5, LANES=4 -> tvalid exactly 7 cycles after input handshake; masked lanes 5..7 never win; equal-distance tie picks the lower index.
- Frame of NUM_CORNERS+2 corners -> all get records, prev_count=NUM_CORNERS; with STATS_EN, stat_dropped=2.
- Hold m00_axis_tready=0 for 20 cycles, then assert reset mid-OUTPUT -> tdata stable while stalled; after reset tvalid=0, prev_count=0, next corner returns match_ok=0.

Source files
------------

// File: rtl/feature_matcher_par.sv
// Streaming BRIEF matcher: each incoming corner is compared against the previous frame's
// ping-pong store, LANES descriptors per cycle. Define STATS_EN for per-frame statistics outputs.
module feature_matcher_par #(
   parameter int NUM_BITS    = 256,
   parameter int COORD_W     = 11,
   parameter int NUM_CORNERS = 1024,
   parameter int LANES       = 4,
   parameter int DIST_W      = 9,
   parameter int IN_W        = 280,
   parameter int OUT_W       = 64
) (
   input  logic                s00_axis_aclk,
   input  logic                s00_axis_aresetn,
   input  logic [IN_W-1:0]     s00_axis_tdata,
   input  logic                s00_axis_tvalid,
   input  logic                s00_axis_tlast,
   output logic                s00_axis_tready,
   output logic [OUT_W-1:0]    m00_axis_tdata,
   output logic                m00_axis_tvalid,
   output logic                m00_axis_tlast,
   input  logic                m00_axis_tready,
   input  logic [DIST_W-1:0]   cfg_max_dist,
   input  logic [3:0]          cfg_ratio_num,
   input  logic [3:0]          cfg_ratio_den
`ifdef STATS_EN
   ,
   output logic [15:0]         stat_matches,
   output logic [15:0]         stat_dropped,
   output logic                stat_frame_done
`endif
);

   localparam int E_W    = NUM_BITS + 2*COORD_W;
   localparam int ROWS   = NUM_CORNERS / LANES;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LB     = $clog2(LANES);
   localparam int PC_W   = $clog2(NUM_CORNERS + 1);
   localparam int PROD_W = DIST_W + 4;
   localparam logic [PC_W-1:0]   NC     = PC_W'(NUM_CORNERS);
   localparam logic [DIST_W-1:0] D_INIT = DIST_W'(NUM_BITS);
   localparam logic [DIST_W-1:0] D_MASK = {DIST_W{1'b1}};

   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, OUTPUT} state_t;

   state_t               state_q, state_n;
   logic                 bank_sel;
   logic [PC_W-1:0]      wr_ptr, prev_count;
   logic [ROW_W-1:0]     scan_row, last_row, row_p0;
   logic [1:0]           drain_cnt;
   logic                 s_tready, m_tvalid, m_tlast;
   logic [OUT_W-1:0]     m_tdata;
   logic                 vld_p0, vld_p1;
   logic                 hs_in, hs_out, wr_en;
   logic [ROW_W-1:0]     wr_row;
   logic [PC_W-1:0]      wr_lane;

   logic [NUM_BITS-1:0]  cur_desc;
   logic [COORD_W-1:0]   cur_x, cur_y;
   logic                 cur_last;

   logic [LANES*DIST_W-1:0]    dist_p1_flat;
   logic [LANES*2*COORD_W-1:0] xy_p1_flat;
   logic [DIST_W-1:0]          d1, d2, m_d1, m_d2, dl;
   logic [2*COORD_W-1:0]       best_xy, m_xy;

   logic [PROD_W-1:0]    prod_l, prod_r;
   logic                 match_ok;
   logic [OUT_W-1:0]     rec;

   function automatic logic [DIST_W-1:0] popcount(input logic [NUM_BITS-1:0] v);
      logic [DIST_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_BITS; i++) c = c + DIST_W'(v[i]);
      return c;
   endfunction

   assign s00_axis_tready = s_tready;
   assign m00_axis_tvalid = m_tvalid;
   assign m00_axis_tlast  = m_tlast;
   assign m00_axis_tdata  = m_tdata;

   assign hs_in   = (state_q == IDLE) && s_tready && s00_axis_tvalid;
   assign hs_out  = (state_q == OUTPUT) && m_tvalid && m00_axis_tready;
   assign wr_en   = hs_in && (wr_ptr < NC);
   assign wr_row  = ROW_W'(wr_ptr >> LB);
   assign wr_lane = wr_ptr & PC_W'(LANES - 1);

   generate
      if (IN_W > E_W) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^s00_axis_tdata[IN_W-1:E_W];
      end
   endgenerate

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (hs_in) state_n = (prev_count != '0) ? SCAN : DECIDE;
         SCAN:    if (scan_row == last_row) state_n = DRAIN;
         DRAIN:   if (drain_cnt == 2'd2) state_n = DECIDE;
         DECIDE:  state_n = OUTPUT;
         OUTPUT:  if (hs_out) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q    <= IDLE;
         s_tready   <= 1'b0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         m_tdata    <= '0;
         bank_sel   <= 1'b0;
         wr_ptr     <= '0;
         prev_count <= '0;
         scan_row   <= '0;
         last_row   <= '0;
         drain_cnt  <= '0;
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
      end else begin
         state_q   <= state_n;
         s_tready  <= (state_n == IDLE);
         vld_p0    <= (state_q == SCAN);
         vld_p1    <= vld_p0;
         scan_row  <= (state_q == SCAN) ? scan_row + ROW_W'(1) : '0;
         drain_cnt <= (state_q == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
         if (hs_in) begin
            last_row <= ROW_W'((prev_count - PC_W'(1)) >> LB);
            if (wr_ptr < NC) wr_ptr <= wr_ptr + PC_W'(1);
         end
         if (state_q == DECIDE) begin
            m_tdata <= rec;
            m_tlast <= cur_last;
         end
         if (state_q == OUTPUT && !m_tvalid) m_tvalid <= 1'b1;
         // Frame swap: the bank just filled becomes the reference for the next frame
         if (hs_out) begin
            m_tvalid <= 1'b0;
            if (m_tlast) begin
               bank_sel   <= ~bank_sel;
               prev_count <= wr_ptr;
               wr_ptr     <= '0;
            end
         end
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (hs_in) begin
         cur_desc <= s00_axis_tdata[NUM_BITS-1:0];
         cur_x    <= s00_axis_tdata[NUM_BITS +: COORD_W];
         cur_y    <= s00_axis_tdata[NUM_BITS+COORD_W +: COORD_W];
         cur_last <= s00_axis_tlast;
      end
      row_p0 <= scan_row;
   end

   // p0: per-lane store read, p1: masked XOR+popcount
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic [E_W-1:0]       mem [2*ROWS];
         logic [E_W-1:0]       rd_p0;
         logic [DIST_W-1:0]    dist_p1;
         logic [2*COORD_W-1:0] xy_p1;
         logic [PC_W-1:0]      idx;

         assign idx = PC_W'(row_p0) * PC_W'(LANES) + PC_W'(l);

         always_ff @(posedge s00_axis_aclk) begin
            if (wr_en && wr_lane == PC_W'(l)) mem[{bank_sel, wr_row}] <= s00_axis_tdata[E_W-1:0];
            rd_p0   <= mem[{~bank_sel, scan_row}];
            dist_p1 <= (idx >= prev_count) ? D_MASK : popcount(rd_p0[NUM_BITS-1:0] ^ cur_desc);
            xy_p1   <= rd_p0[E_W-1:NUM_BITS];
         end

         assign dist_p1_flat[l*DIST_W +: DIST_W]       = dist_p1;
         assign xy_p1_flat[l*2*COORD_W +: 2*COORD_W]   = xy_p1;
      end
   endgenerate

   // p2: ascending-lane merge keeps the lowest index on equal distance
   always_comb begin
      m_d1 = d1;
      m_d2 = d2;
      m_xy = best_xy;
      dl   = '0;
      for (int l = 0; l < LANES; l++) begin
         dl = dist_p1_flat[l*DIST_W +: DIST_W];
         if (dl < m_d1) begin
            m_d2 = m_d1;
            m_d1 = dl;
            m_xy = xy_p1_flat[l*2*COORD_W +: 2*COORD_W];
         end else if (dl < m_d2) begin
            m_d2 = dl;
         end
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (hs_in) begin
         d1      <= D_INIT;
         d2      <= D_INIT;
         best_xy <= '0;
      end else if (vld_p1) begin
         d1      <= m_d1;
         d2      <= m_d2;
         best_xy <= m_xy;
      end
   end

   always_comb begin
      prod_l   = PROD_W'(d1) * PROD_W'(cfg_ratio_den);
      prod_r   = PROD_W'(d2) * PROD_W'(cfg_ratio_num);
      match_ok = (prev_count != '0) && (d1 < cfg_max_dist) &&
                 ((cfg_ratio_den == 4'd0) || (prod_l < prod_r));
      rec = OUT_W'({(match_ok ? best_xy : {2*COORD_W{1'b0}}), cur_y, cur_x, d1, match_ok});
   end

`ifdef STATS_EN
   logic [15:0] cnt_match, cnt_drop;

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         cnt_match       <= '0;
         cnt_drop        <= '0;
         stat_matches    <= '0;
         stat_dropped    <= '0;
         stat_frame_done <= 1'b0;
      end else begin
         stat_frame_done <= 1'b0;
         if (state_q == DECIDE && match_ok && cnt_match != 16'hFFFF) cnt_match <= cnt_match + 16'd1;
         if (hs_in && wr_ptr >= NC && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
         if (hs_out && m_tlast) begin
            stat_matches    <= cnt_match;
            stat_dropped    <= cnt_drop;
            stat_frame_done <= 1'b1;
            cnt_match       <= '0;
            cnt_drop        <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_feature_matcher_par.sv
// Scoreboard bench for feature_matcher_par: driver pushes model results, monitor pops on output.
module tb_feature_matcher_par;
   localparam int NUM_BITS = 256, COORD_W = 11, NUM_CORNERS = 16, LANES = 4;
   localparam int DIST_W = 9, IN_W = 280, OUT_W = 64;

   logic clk = 0, rst_n = 0;
   logic [IN_W-1:0]   s_tdata = '0;
   logic              s_tvalid = 0, s_tlast = 0, s_tready;
   logic [OUT_W-1:0]  m_tdata;
   logic              m_tvalid, m_tlast, m_tready = 0;
   logic [DIST_W-1:0] cfg_max_dist = '0;
   logic [3:0]        cfg_ratio_num = '0, cfg_ratio_den = '0;
`ifdef STATS_EN
   logic [15:0] stat_matches, stat_dropped;
   logic        stat_frame_done;
`endif

   always #5 clk = ~clk;

   feature_matcher_par #(.NUM_BITS(NUM_BITS), .COORD_W(COORD_W), .NUM_CORNERS(NUM_CORNERS),
                         .LANES(LANES), .DIST_W(DIST_W), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
      .s00_axis_tready(s_tready),
      .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
      .m00_axis_tready(m_tready),
      .cfg_max_dist(cfg_max_dist), .cfg_ratio_num(cfg_ratio_num), .cfg_ratio_den(cfg_ratio_den)
`ifdef STATS_EN
      , .stat_matches(stat_matches), .stat_dropped(stat_dropped), .stat_frame_done(stat_frame_done)
`endif
   );

   typedef struct { logic [COORD_W-1:0] x, y; logic [NUM_BITS-1:0] d; } ent_t;
   typedef struct { logic [OUT_W-1:0] data; logic last; int lat; int hs; } exp_t;

   exp_t exp_q[$];
   ent_t prev_f[$], cur_f[$];
   int   frame_matches = 0, frame_drops = 0, last_matches = 0, last_drops = 0;
   int   errors = 0, checks = 0;
   int   cyc = 0;
   bit   stall = 0, busy = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NUM_BITS-1:0] rand_desc();
      logic [NUM_BITS-1:0] d;
      for (int i = 0; i < NUM_BITS/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [NUM_BITS-1:0] flip(input logic [NUM_BITS-1:0] d, input int k);
      logic [NUM_BITS-1:0] t;
      t = d;
      while ($countones(t ^ d) != k) t[$urandom_range(0, NUM_BITS-1)] ^= 1'b1;
      return t;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.x = COORD_W'($urandom_range(0, 2047));
      e.y = COORD_W'($urandom_range(0, 2047));
      e.d = rand_desc();
      return e;
   endfunction

   function automatic ent_t make_query();
      ent_t e;
      e = rand_ent();
      if (prev_f.size() > 0 && $urandom_range(0, 1) == 1)
         e.d = flip(prev_f[$urandom_range(0, prev_f.size()-1)].d, $urandom_range(0, 30));
      return e;
   endfunction

   // Reference: brute-force nearest / second-nearest over the stored previous frame
   function automatic exp_t model(input ent_t c, input logic last, input int maxd, input int num, input int den);
      exp_t e;
      int d, d1, d2, best;
      logic ok;
      logic [COORD_W-1:0] px, py;
      d1 = NUM_BITS; d2 = NUM_BITS; best = -1;
      foreach (prev_f[i]) begin
         d = $countones(prev_f[i].d ^ c.d);
         if (d < d1) begin d1 = d; best = i; end
      end
      if (best >= 0)
         foreach (prev_f[j]) begin
            d = $countones(prev_f[j].d ^ c.d);
            if (j != best && d < d2) d2 = d;
         end
      ok = (prev_f.size() > 0) && (d1 < maxd) && (den == 0 || d1*den < d2*num);
      px = ok ? prev_f[best].x : '0;
      py = ok ? prev_f[best].y : '0;
      e.data = OUT_W'({py, px, c.y, c.x, DIST_W'(d1), ok});
      e.last = last;
      e.lat  = (prev_f.size() == 0) ? 2 : (prev_f.size() + LANES - 1) / LANES + 5;
      e.hs   = 0;
      return e;
   endfunction

   task automatic send(input ent_t c, input logic last, input int maxd, input int num, input int den);
      exp_t e;
      int t = 0;
      @(negedge clk);
      while (!s_tready && t < 2000) begin @(negedge clk); t++; end
      if (!s_tready) begin
         chk("in_ready_timeout", 64'(s_tready), 64'd1);
         return;
      end
      cfg_max_dist  = DIST_W'(maxd);
      cfg_ratio_num = 4'(num);
      cfg_ratio_den = 4'(den);
      s_tdata  = IN_W'({c.y, c.x, c.d});
      s_tlast  = last;
      s_tvalid = 1;
      e = model(c, last, maxd, num, den);
      e.hs = cyc;
      exp_q.push_back(e);
      if (e.data[0]) frame_matches++;
      if (cur_f.size() < NUM_CORNERS) cur_f.push_back(c);
      else frame_drops++;
      if (last) begin
         prev_f = cur_f;
         cur_f.delete();
         last_matches = frame_matches; last_drops = frame_drops;
         frame_matches = 0; frame_drops = 0;
      end
      @(posedge clk);
      #1 s_tvalid = 0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 5000) begin @(negedge clk); t++; end
      if (exp_q.size() != 0 || busy) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 m_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      exp_t cur;
      logic [OUT_W-1:0] held;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
         end else if (m_tvalid) begin
            if (!busy) begin
               busy = 1;
               held = m_tdata;
               if (exp_q.size() == 0) begin
                  chk("unexpected_record", 64'(m_tdata), 64'd0);
                  cur.data = m_tdata; cur.last = m_tlast;
               end else begin
                  cur = exp_q.pop_front();
                  chk("latency", 64'(cyc - cur.hs - 1), 64'(cur.lat));
               end
            end else begin
               chk("stall_stable", 64'(m_tdata), 64'(held));
            end
            if (m_tready) begin
               chk("tdata", 64'(m_tdata), 64'(cur.data));
               chk("tlast", 64'(m_tlast), 64'(cur.last));
               busy = 0;
            end
         end
      end
   end

   initial begin
      ent_t a[3], b, o[18], c5[5], q;
      int t, n;
      #2;
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("idle_tready", 64'(s_tready), 64'd1);

      // Frame A: no reference yet; a2 sits 1 bit from a0
      for (int i = 0; i < 3; i++) a[i] = rand_ent();
      a[2].d = a[0].d ^ 256'd1;
      for (int i = 0; i < 3; i++) send(a[i], i == 2, 40, 4, 5);

      // Frame B: exact match of a1, then a ratio-test reject near a0/a2
      b = rand_ent(); b.d = a[1].d;
      send(b, 0, 40, 4, 5);
      b = rand_ent(); b.d = a[0].d ^ (256'h7FE);
      send(b, 1, 40, 4, 5);

      // Frame O overflows the store by two corners
      for (int i = 0; i < 18; i++) begin
         o[i] = make_query();
         send(o[i], i == 17, $urandom_range(0, 300), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      wait_drain();
`ifdef STATS_EN
      repeat (2) @(negedge clk);
      chk("stat_dropped", 64'(stat_dropped), 64'd2);
      chk("stat_matches", 64'(stat_matches), 64'(last_matches));
`endif
      q = make_query();
      send(q, 1, 100, 8, 8);

      // Frame C: 5 corners over the bank still holding O[5..7]; c1 and c3 share a descriptor
      for (int i = 0; i < 5; i++) c5[i] = rand_ent();
      c5[3].d = c5[1].d;
      for (int i = 0; i < 5; i++) send(c5[i], i == 4, 40, 4, 5);

      // Frame D: stale entries must stay masked; tie resolves to the lower index
      q = rand_ent(); q.d = o[5].d; send(q, 0, 300, 15, 0);
      q = rand_ent(); q.d = o[6].d; send(q, 0, 300, 15, 0);
      q = rand_ent(); q.d = o[7].d; send(q, 0, 300, 15, 0);
      q = rand_ent(); q.d = c5[1].d; send(q, 0, 40, 1, 0);
      q = rand_ent(); q.d = flip(c5[2].d, 3); send(q, 1, 40, 1, 2);

      // Random frames
      for (int f = 0; f < 6; f++) begin
         n = (f == 2) ? 18 : $urandom_range(1, 9);
         for (int i = 0; i < n; i++) begin
            q = make_query();
            send(q, i == n-1, $urandom_range(0, 300), $urandom_range(0, 15), $urandom_range(0, 15));
         end
      end
      wait_drain();

      // Stall output, then reset while the record is pending
      stall = 1;
      q = make_query();
      send(q, 0, 300, 15, 0);
      t = 0;
      while (!m_tvalid && t < 200) begin @(negedge clk); t++; end
      chk("stall_tvalid", 64'(m_tvalid), 64'd1);
      repeat (20) @(negedge clk);
      rst_n = 0;
      exp_q.delete();
      prev_f.delete(); cur_f.delete();
      frame_matches = 0; frame_drops = 0;
      #2;
      chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
      chk("midrst_tdata", 64'(m_tdata), 64'd0);
      chk("midrst_tready", 64'(s_tready), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      stall = 0;
      q = rand_ent();
      send(q, 1, 300, 15, 0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
